// File: rtl/ifetch_buffer_if.sv
// ----------------------------------------------------------------------------
// ifetch_buffer_if
// Groups the instruction-memory bus, the decode handshake and the redirect
// control of the fetch stage into one bundle.
//   master : the fetch buffer itself. It drives iaddr to memory, and it drives
//            instr/instr_pc/instr_valid, fill_level and misalign to decode.
//   slave  : the surroundings (memory, decode, branch unit). They drive idata,
//            fetch_en, redirect_valid/redirect_pc and instr_ready.
// Parameter CNT_W : width of fill_level.
// ----------------------------------------------------------------------------
interface ifetch_buffer_if #(
    parameter int CNT_W = 2
) ();
    logic              fetch_en;
    logic [31:0]       iaddr;
    logic [31:0]       idata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic [CNT_W-1:0]  fill_level;
    logic              misalign;

    modport master (
        input  fetch_en, idata, redirect_valid, redirect_pc, instr_ready,
        output iaddr, instr_valid, instr, instr_pc, fill_level, misalign
    );

    modport slave (
        output fetch_en, idata, redirect_valid, redirect_pc, instr_ready,
        input  iaddr, instr_valid, instr, instr_pc, fill_level, misalign
    );
endinterface

// File: rtl/ifetch_buffer.sv
// ----------------------------------------------------------------------------
// ifetch_buffer
// Instruction fetch stage. It owns the fetch PC and presents it as the memory
// byte address. It captures the word that memory returns in the same cycle and
// queues {pc, word} in a small FIFO. Decode drains that FIFO with a
// valid/ready handshake. A redirect flushes the FIFO and reloads the PC.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : ifetch_buffer_if.master (memory bus, decode handshake, redirect)
// Parameters:
//   RESET_PC : first byte address fetched after reset
//   DEPTH    : number of FIFO entries (power of 2, >= 2)
//   CNT_W    : width of fill_level (holds 0..DEPTH)
// ----------------------------------------------------------------------------
module ifetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2,
    parameter int          CNT_W    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    ifetch_buffer_if.master      bus
);
    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW-1:0]    PTR_ZERO = AW'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [31:0]      mem_pc_q   [DEPTH];
    logic [31:0]      mem_data_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             misalign_q, misalign_d;
    logic             head_valid_s;
    logic             pop_s;
    logic             push_s;

    // Handshake qualifiers: a redirect blocks both pop and push, so a head
    // offered together with a redirect is squashed and not consumed.
    always_comb begin
        head_valid_s = (count_q != CNT_ZERO);
        pop_s        = head_valid_s & bus.instr_ready & ~bus.redirect_valid;
        push_s       = bus.fetch_en & ~bus.redirect_valid &
                       ((count_q < CNT_FULL) | pop_s);
    end

    // Next-state logic for the pointers, the occupancy count, the PC and the misalign flag.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        misalign_d = bus.redirect_valid & (|bus.redirect_pc[1:0]);
        if (bus.redirect_valid) begin
            rd_ptr_d   = PTR_ZERO;
            wr_ptr_d   = PTR_ZERO;
            count_d    = CNT_ZERO;
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
        end else begin
            if (push_s) begin
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                fetch_pc_d = fetch_pc_q + 32'd4;  // wraps modulo 2^32
            end else begin
                wr_ptr_d   = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            // A simultaneous push and pop leaves the count unchanged, even when the FIFO is full.
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q   <= PTR_ZERO;
            wr_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    // FIFO storage: captures the combinationally returned word with its PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= 32'h0000_0000;
                mem_data_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
            mem_data_q[wr_ptr_q] <= bus.idata;
        end
    end

    // Head presentation: the outputs are forced to zero whenever the FIFO is empty.
    always_comb begin
        if (head_valid_s) begin
            bus.instr    = mem_data_q[rd_ptr_q];
            bus.instr_pc = mem_pc_q[rd_ptr_q];
        end else begin
            bus.instr    = 32'h0000_0000;
            bus.instr_pc = 32'h0000_0000;
        end
    end

    assign bus.instr_valid = head_valid_s;
    assign bus.iaddr       = fetch_pc_q;
    assign bus.fill_level  = count_q;
    assign bus.misalign    = misalign_q;

endmodule

// File: tb/tb_ifetch_buffer.sv
module tb_ifetch_buffer;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ifetch_buffer_if #(.CNT_W(2)) bus ();

    ifetch_buffer #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2),
        .CNT_W    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: word[k] = k + 0x100, where k is the word index of the byte address.
    assign bus.idata = {2'b00, bus.iaddr[31:2]} + 32'h0000_0100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [1:0]  e_fill;
        logic [31:0] e_iaddr;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic fe, input logic rdy, input logic rv,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc, input logic [31:0] ei,
                                input logic [1:0] ef, input logic [31:0] ea,
                                input logic em);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ei;
        v.e_fill = ef; v.e_iaddr = ea; v.e_mis = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] ei, input logic [1:0] ef,
                           input logic [31:0] ea, input logic em);
        chk({tag, ".valid"},    {31'd0, bus.instr_valid}, {31'd0, ev});
        chk({tag, ".instr_pc"}, bus.instr_pc, epc);
        chk({tag, ".instr"},    bus.instr, ei);
        chk({tag, ".fill"},     {30'd0, bus.fill_level}, {30'd0, ef});
        chk({tag, ".iaddr"},    bus.iaddr, ea);
        chk({tag, ".misalign"}, {31'd0, bus.misalign}, {31'd0, em});
    endtask

    task automatic step(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        bus.fetch_en       = fe;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Stream from reset, then backpressure.
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'h0000_0100, 2'd1, 32'h0000_0004, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 32'h0000_0101, 2'd1, 32'h0000_0008, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0008, 32'h0000_0102, 2'd1, 32'h0000_000C, 1'b0));
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0008, 32'h0000_0102, 2'd2, 32'h0000_0010, 1'b0));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0008, 32'h0000_0102, 2'd2, 32'h0000_0010, 1'b0));
        // Full with a simultaneous pop: the count stays at 2 and there is no bubble.
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_000C, 32'h0000_0103, 2'd2, 32'h0000_0014, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0010, 32'h0000_0104, 2'd2, 32'h0000_0018, 1'b0));
        // Redirect while full with ready high: the head is squashed.
        vq.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0000_0040, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0040, 32'h0000_0110, 2'd1, 32'h0000_0044, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0044, 32'h0000_0111, 2'd1, 32'h0000_0048, 1'b0));
        // Misaligned redirect.
        vq.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0000_0043, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0000_0040, 1'b1));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0040, 32'h0000_0110, 2'd1, 32'h0000_0044, 1'b0));
        // PC wrap.
        vq.push_back(mk(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 2'd0, 32'hFFFF_FFFC, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h4000_00FF, 2'd1, 32'h0000_0000, 1'b0));
        vq.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'h0000_0100, 2'd1, 32'h0000_0004, 1'b0));
        // Fill, then drop fetch_en: the FIFO drains and iaddr holds.
        vq.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0000, 32'h0000_0100, 2'd2, 32'h0000_0008, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0004, 32'h0000_0101, 2'd1, 32'h0000_0008, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0000_0008, 1'b0));
        vq.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'd0, 32'h0000_0008, 1'b0));

        // Reset state.
        reset              = 1'b0;
        bus.fetch_en       = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0000_0000;
        #2;
        chk_all("reset", 1'b0, 32'h0, 32'h0, 2'd0, 32'h0000_0000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].fe, vq[i].rdy, vq[i].rv, vq[i].rpc);
            chk_all($sformatf("vec%0d", i), vq[i].e_valid, vq[i].e_pc, vq[i].e_instr,
                    vq[i].e_fill, vq[i].e_iaddr, vq[i].e_mis);
            @(negedge clk);
        end

        // Back-to-back misaligned redirects keep misalign high, and it clears afterwards.
        step(1'b1, 1'b1, 1'b1, 32'h0000_0081);
        chk_all("mis_a", 1'b0, 32'h0, 32'h0, 2'd0, 32'h0000_0080, 1'b1);
        @(negedge clk);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0102);
        chk_all("mis_b", 1'b0, 32'h0, 32'h0, 2'd0, 32'h0000_0100, 1'b1);
        @(negedge clk);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk_all("mis_c", 1'b1, 32'h0000_0100, 32'h0000_0140, 2'd1, 32'h0000_0104, 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-stream with the FIFO full.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk_all("pre_rst", 1'b1, 32'h0000_0100, 32'h0000_0140, 2'd2, 32'h0000_0108, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 32'h0, 32'h0, 2'd0, 32'h0000_0000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk_all("post_rst", 1'b1, 32'h0000_0000, 32'h0000_0100, 2'd1, 32'h0000_0004, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
